// File: rtl/seg_pkg.sv
// Shared types, glyph table and constant helpers for the seven-segment scan driver.
// Glyphs are active-high with bit 0 = segment a ... bit 6 = segment g.
package seg_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } conv_state_t;

  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_DASH  = 7'h40;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  // Index width, never below one bit so single-entry counters still elaborate.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  function automatic logic [6:0] glyph_of(input bcd_t n);
    logic [6:0] g;
    case (n)
      4'd0:    g = GLYPH_0;
      4'd1:    g = GLYPH_1;
      4'd2:    g = GLYPH_2;
      4'd3:    g = GLYPH_3;
      4'd4:    g = GLYPH_4;
      4'd5:    g = GLYPH_5;
      4'd6:    g = GLYPH_6;
      4'd7:    g = GLYPH_7;
      4'd8:    g = GLYPH_8;
      4'd9:    g = GLYPH_9;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: start accepted only while idle, one bit per cycle,
// done_vld pulses with the result during the last busy cycle (DATA_W cycles busy).
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int DATA_W = 14,
  parameter int DIGITS = 4
) (
  input  logic                    Sys_CLK,
  input  logic                    Sys_RST,
  input  logic                    start_vld,
  input  logic [DATA_W-1:0]       din_dat,
  output logic                    busy,
  output logic                    done_vld,
  output bcd_t [DIGITS-1:0]       res_dat,
  output logic                    res_ovf
);

  localparam int          ITER_W = clog2(DATA_W);
  localparam logic [63:0] LIMIT  = pow10(DIGITS);

  conv_state_t       state_q, state_d;
  logic [DATA_W-1:0] bin_q;
  bcd_t [DIGITS-1:0] work_q, work_d;
  logic [ITER_W-1:0] iter_q;
  logic              ovf_next_q;
  logic              accept, last_iter;
  logic [4*DIGITS-1:0] adj_flat;

  assign last_iter = (iter_q == ITER_W'(DATA_W - 1));

  always_ff @(posedge Sys_CLK) begin
    if (Sys_RST) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_vld) state_d = ST_CONV;
      ST_CONV: if (last_iter) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == ST_CONV);
    accept   = (state_q == ST_IDLE) && start_vld;
    done_vld = (state_q == ST_CONV) && last_iter;
  end

  // Upper nibbles beyond DIGITS are dropped; such values are flagged by the overflow compare.
  always_comb begin
    adj_flat = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj_flat[4*i +: 4] = (work_q[i] >= 4'd5) ? work_q[i] + 4'd3 : work_q[i];
    end
    work_d = {adj_flat[4*DIGITS-2:0], bin_q[DATA_W-1]};
  end

  always_ff @(posedge Sys_CLK) begin
    if (Sys_RST) begin
      bin_q      <= '0;
      work_q     <= '0;
      iter_q     <= '0;
      ovf_next_q <= 1'b0;
    end else if (accept) begin
      bin_q      <= din_dat;
      work_q     <= '0;
      iter_q     <= '0;
      ovf_next_q <= (64'(din_dat) >= LIMIT);
    end else if (busy) begin
      bin_q  <= bin_q << 1;
      work_q <= work_d;
      iter_q <= iter_q + ITER_W'(1);
    end
  end

  assign res_dat = work_d;
  assign res_ovf = ovf_next_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Multi-digit seven-segment scan driver: binary in, BCD via bin2bcd_seq, registered COM/SEG out.
// Outputs lag the scan state by one cycle; Load is ignored (not queued) while Busy.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int DATA_W      = 14,
  parameter int SCAN_DIV    = 50000,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit COM_ACT_LOW = 1'b1
) (
  input  logic              Sys_CLK,
  input  logic              Sys_RST,
  input  logic [DATA_W-1:0] Data_Bin,
  input  logic              Load,
  input  logic              EN,
  input  logic              Blank_Lz,
  input  logic [DIGITS-1:0] Dp_Mask,
  output logic              Busy,
  output logic              Overflow,
  output logic [DIGITS-1:0] COM,
  output logic [7:0]        SEG
);

  localparam int                IDX_W   = clog2(DIGITS);
  localparam int                CNT_W   = clog2(SCAN_DIV);
  localparam logic [7:0]        SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] COM_OFF = COM_ACT_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  bcd_t [DIGITS-1:0] disp_q, res_dat;
  logic              res_ovf, done_vld;
  logic [CNT_W-1:0]  dwell_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DIGITS-1:0] upper_zero;
  logic [6:0]        glyph;
  logic [7:0]        seg_d;
  logic [DIGITS-1:0] com_d;

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .Sys_CLK   (Sys_CLK),
    .Sys_RST   (Sys_RST),
    .start_vld (Load),
    .din_dat   (Data_Bin),
    .busy      (Busy),
    .done_vld  (done_vld),
    .res_dat   (res_dat),
    .res_ovf   (res_ovf)
  );

  always_ff @(posedge Sys_CLK) begin
    if (Sys_RST) begin
      disp_q   <= '0;
      Overflow <= 1'b0;
    end else if (done_vld) begin
      disp_q   <= res_dat;
      Overflow <= res_ovf;
    end
  end

  // Scan keeps running with EN low so re-enabling resumes at the same phase.
  always_ff @(posedge Sys_CLK) begin
    if (Sys_RST) begin
      dwell_q <= '0;
      idx_q   <= '0;
    end else if (dwell_q == CNT_W'(SCAN_DIV - 1)) begin
      dwell_q <= '0;
      idx_q   <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      dwell_q <= dwell_q + CNT_W'(1);
    end
  end

  always_comb begin
    upper_zero = '0;
    for (int i = 0; i < DIGITS; i++) begin
      upper_zero[i] = 1'b1;
      for (int j = i; j < DIGITS; j++) begin
        if (disp_q[j] != 4'd0) upper_zero[i] = 1'b0;
      end
    end
  end

  always_comb begin
    glyph = glyph_of(disp_q[idx_q]);
    if (Overflow)
      glyph = GLYPH_DASH;
    else if (Blank_Lz && (idx_q != '0) && upper_zero[idx_q])
      glyph = GLYPH_BLANK;

    seg_d        = {Dp_Mask[idx_q], glyph};
    com_d        = '0;
    com_d[idx_q] = 1'b1;
    if (!EN) begin
      seg_d = '0;
      com_d = '0;
    end
  end

  // Polarity folded in before the flop so the pins come straight from registers.
  always_ff @(posedge Sys_CLK) begin
    if (Sys_RST) begin
      SEG <= SEG_OFF;
      COM <= COM_OFF;
    end else begin
      SEG <= seg_d ^ SEG_OFF;
      COM <= com_d ^ COM_OFF;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: loaded values queued, checked on conversion end and across a scan.
module tb_seg_scan_driver;

  localparam int DIGITS   = 4;
  localparam int DATA_W   = 14;
  localparam int SCAN_DIV = 4;

  logic              Sys_CLK = 1'b0;
  logic              Sys_RST;
  logic [DATA_W-1:0] Data_Bin;
  logic              Load;
  logic              EN;
  logic              Blank_Lz;
  logic [DIGITS-1:0] Dp_Mask;
  logic              Busy;
  logic              Overflow;
  logic [DIGITS-1:0] COM;
  logic [7:0]        SEG;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  // Active-low patterns for 0..9 with dp off.
  logic [7:0] seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  always #5 Sys_CLK = ~Sys_CLK;

  seg_scan_driver #(
    .DIGITS      (DIGITS),
    .DATA_W      (DATA_W),
    .SCAN_DIV    (SCAN_DIV),
    .SEG_ACT_LOW (1'b1),
    .COM_ACT_LOW (1'b1)
  ) dut (
    .Sys_CLK  (Sys_CLK),
    .Sys_RST  (Sys_RST),
    .Data_Bin (Data_Bin),
    .Load     (Load),
    .EN       (EN),
    .Blank_Lz (Blank_Lz),
    .Dp_Mask  (Dp_Mask),
    .Busy     (Busy),
    .Overflow (Overflow),
    .COM      (COM),
    .SEG      (SEG)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int v, input bit blank, input logic [3:0] dp, input int i);
    int p;
    logic [7:0] s;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    if (v >= 10000)                    s = 8'hBF;
    else if (blank && i > 0 && v < p)  s = 8'hFF;
    else                               s = seg_tbl[(v / p) % 10];
    s[7] = ~dp[i];
    return s;
  endfunction

  function automatic int com_idx(input logic [3:0] c);
    int r;
    r = -1;
    for (int k = 0; k < 4; k++) begin
      if (c[k] == 1'b0) r = (r == -1) ? k : -2;
    end
    return r;
  endfunction

  task automatic start_load(input int v, input bit expect_accept);
    @(negedge Sys_CLK);
    Data_Bin = DATA_W'(v);
    Load     = 1'b1;
    if (expect_accept) exp_q.push_back(v);
    @(negedge Sys_CLK);
    Load = 1'b0;
  endtask

  task automatic wait_done(output int v, output int nbusy);
    nbusy = 0;
    while (Busy === 1'b1 && nbusy < 100) begin
      nbusy++;
      @(negedge Sys_CLK);
    end
    chk("done_timeout", 32'(nbusy < 100), 32'd1);
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      v = 0;
    end else begin
      v = exp_q.pop_front();
    end
    chk("overflow", 32'(Overflow), 32'(v >= 10000));
  endtask

  task automatic scan_check(input int v, input bit blank, input logic [3:0] dp);
    int prev, run, idx;
    bit full;
    logic [3:0] seen;
    prev = -1; run = 0; full = 1'b0; seen = '0;
    for (int s = 0; s < 20; s++) begin
      @(negedge Sys_CLK);
      idx = com_idx(COM);
      chk("com_onehot", 32'($countones(~COM)), 32'd1);
      if (idx >= 0) begin
        chk($sformatf("seg_d%0d_v%0d", idx, v), 32'(SEG), 32'(exp_seg(v, blank, dp, idx)));
        seen[idx] = 1'b1;
        if (idx == prev) begin
          run++;
        end else begin
          if (prev >= 0) begin
            chk("scan_order", 32'(idx), 32'((prev + 1) % 4));
            if (full) chk("dwell_len", 32'(run), 32'(SCAN_DIV));
            full = 1'b1;
          end
          prev = idx;
          run  = 1;
        end
      end
    end
    chk("all_digits", 32'(seen), 32'hF);
  endtask

  initial begin
    int v, nb, prev, cur, guard;

    Sys_RST = 1'b1; Load = 1'b0; EN = 1'b1; Blank_Lz = 1'b0;
    Dp_Mask = '0; Data_Bin = '0;

    // Reset
    repeat (3) @(negedge Sys_CLK);
    chk("rst_com", 32'(COM), 32'hF);
    chk("rst_seg", 32'(SEG), 32'hFF);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_ovf", 32'(Overflow), 32'd0);
    Sys_RST = 1'b0;
    @(negedge Sys_CLK);
    chk("post_rst_com", 32'(COM), 32'hE);
    chk("post_rst_seg", 32'(SEG), 32'hC0);

    // Conversion
    start_load(1234, 1'b1);
    wait_done(v, nb);
    chk("busy_len", 32'(nb), 32'd14);
    scan_check(v, 1'b0, 4'b0000);

    // Blanking
    Blank_Lz = 1'b1;
    start_load(7, 1'b1);
    wait_done(v, nb);
    scan_check(v, 1'b1, 4'b0000);
    start_load(0, 1'b1);
    wait_done(v, nb);
    scan_check(v, 1'b1, 4'b0000);
    Blank_Lz = 1'b0;

    // Overflow
    start_load(10000, 1'b1);
    wait_done(v, nb);
    chk("busy_len_ovf", 32'(nb), 32'd14);
    scan_check(v, 1'b0, 4'b0000);
    start_load(9999, 1'b1);
    wait_done(v, nb);
    scan_check(v, 1'b0, 4'b0000);

    // Load while busy is dropped
    start_load(4321, 1'b1);
    repeat (4) @(negedge Sys_CLK);
    Data_Bin = DATA_W'(8888);
    Load     = 1'b1;
    @(negedge Sys_CLK);
    Load = 1'b0;
    wait_done(v, nb);
    scan_check(v, 1'b0, 4'b0000);

    // Enable off/on keeps scan phase
    prev = com_idx(COM);
    cur  = prev;
    guard = 0;
    while (cur == prev && guard < 10) begin
      @(negedge Sys_CLK);
      cur = com_idx(COM);
      guard++;
    end
    chk("en_sync", 32'(guard < 10), 32'd1);
    EN = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge Sys_CLK);
      if (k == 2) begin
        chk("en0_com", 32'(COM), 32'hF);
        chk("en0_seg", 32'(SEG), 32'hFF);
      end
      if (k == 10) EN = 1'b1;
      if (k == 11) chk("en_phase_a", 32'(com_idx(COM)), 32'((cur + 2) % 4));
      if (k == 12) chk("en_phase_b", 32'(com_idx(COM)), 32'((cur + 3) % 4));
    end

    // Decimal point on digit 2 only
    Dp_Mask = 4'b0100;
    scan_check(4321, 1'b0, 4'b0100);
    Dp_Mask = 4'b0000;

    // Reset mid-conversion
    start_load(12345, 1'b1);
    wait_done(v, nb);
    start_load(5678, 1'b1);
    repeat (4) @(negedge Sys_CLK);
    Sys_RST = 1'b1;
    @(negedge Sys_CLK);
    chk("midrst_busy", 32'(Busy), 32'd0);
    Sys_RST = 1'b0;
    exp_q.delete();
    chk("midrst_ovf", 32'(Overflow), 32'd0);
    scan_check(0, 1'b0, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
